// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-slave state type, used by the read slave
// and the burst address generator.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } rd_state_t;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst next-address calculator (FIXED / INCR / WRAP).
// Kept separate so a future write slave can reuse it.
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [63:0] addr,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [63:0] next_addr
);

    logic [63:0] step;
    logic [63:0] container;
    logic [63:0] wrap_mask;
    logic [63:0] incr_addr;

    // The wrap container is step*(len+1); legal wrap lengths make it a power of two,
    // so the wrapped address is the container base OR the low bits of the increment.
    always_comb begin
        step      = 64'd1 << size;
        container = ({56'd0, len} + 64'd1) << size;
        wrap_mask = container - 64'd1;
        incr_addr = addr + step;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_mem_slave.sv
// AXI4 read-only memory slave with programmable latency and a backdoor write port.
// Define AXI_RD_STALL_EN to insert LFSR-driven one-cycle RVALID bubbles in bursts.
module axi_rd_mem_slave
    import axi_pkg::*;
#(
    parameter int          ID_W       = 4,
    parameter int          DATA_W     = 64,
    parameter int          MEM_WORDS  = 4096,
    parameter logic [63:0] MEM_BASE   = 64'h8000_0000,
    parameter int          RD_LATENCY = 2,
    parameter logic [15:0] STALL_SEED = 16'hACE1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   ARID,
    input  logic [63:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    input  logic              bd_wen,
    input  logic [63:0]       bd_waddr,
    input  logic [DATA_W-1:0] bd_wdata,
    input  logic [7:0]        bd_wstrb
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 3;
    localparam logic [7:0]  LAT_INIT  = 8'(RD_LATENCY - 1);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    rd_state_t         state;
    rd_state_t         next_state;

    logic [ID_W-1:0]   id_q;
    logic [63:0]       addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              slverr_q;
    logic [7:0]        lat_cnt;
    logic [7:0]        beat_cnt;

    logic              arready_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic [1:0]        rresp_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              ar_hs;
    logic              rd_hs;
    logic              stall;
    logic              load_beat;
    logic              drop_valid;
    logic [1:0]        beat_resp;
    logic [63:0]       next_addr;

    logic [63:0]       rd_off;
    logic              rd_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic [63:0]       bd_off;
    logic              bd_in_range;
    logic [IDX_W-1:0]  bd_idx;

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;

    assign ar_hs = ARVALID && arready_q;
    assign rd_hs = rvalid_q && RREADY;

    axi_burst_addr_gen u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

`ifdef AXI_RD_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running, bit0 requests a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= STALL_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = lfsr[0];
`else
    logic unused_stall_seed;

    assign stall             = 1'b0;
    assign unused_stall_seed = ^STALL_SEED;
`endif

    always_comb begin
        rd_off      = addr_q - MEM_BASE;
        rd_in_range = (addr_q >= MEM_BASE) && (rd_off < MEM_BYTES);
        rd_idx      = rd_off[IDX_W+2:3];
        bd_off      = bd_waddr - MEM_BASE;
        bd_in_range = (bd_waddr >= MEM_BASE) && (bd_off < MEM_BYTES);
        bd_idx      = bd_off[IDX_W+2:3];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ar_hs)              next_state = WAIT;
            WAIT:    if (lat_cnt == 8'd0)    next_state = BURST;
            BURST:   if (rd_hs && rlast_q)   next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    // A beat is loaded when latency expires, on a non-final handshake (unless a
    // bubble is requested), or in the cycle after a bubble.
    always_comb begin
        load_beat  = 1'b0;
        drop_valid = 1'b0;
        case (state)
            WAIT: load_beat = (lat_cnt == 8'd0);
            BURST: begin
                if (!rvalid_q) begin
                    load_beat = 1'b1;
                end else if (rd_hs) begin
                    if (rlast_q || stall) begin
                        drop_valid = 1'b1;
                    end else begin
                        load_beat = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (slverr_q) begin
            beat_resp = RESP_SLVERR;
        end else if (!rd_in_range) begin
            beat_resp = RESP_DECERR;
        end else begin
            beat_resp = RESP_OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            slverr_q  <= 1'b0;
            lat_cnt   <= '0;
            beat_cnt  <= '0;
        end else begin
            arready_q <= (next_state == IDLE);
            if (ar_hs) begin
                id_q     <= ARID;
                addr_q   <= ARADDR;
                len_q    <= ARLEN;
                size_q   <= ARSIZE;
                burst_q  <= ARBURST;
                slverr_q <= (ARSIZE > 3'd3) ||
                            ((ARBURST == BURST_WRAP) && !wrap_len_ok(ARLEN));
                lat_cnt  <= LAT_INIT;
                beat_cnt <= 8'd0;
            end else if ((state == WAIT) && (lat_cnt != 8'd0)) begin
                lat_cnt <= lat_cnt - 8'd1;
            end
            if (load_beat) begin
                rvalid_q <= 1'b1;
                rid_q    <= id_q;
                rresp_q  <= beat_resp;
                rlast_q  <= (beat_cnt == len_q);
                rdata_q  <= (beat_resp == RESP_OKAY) ? mem[rd_idx] : '0;
                addr_q   <= next_addr;
                beat_cnt <= beat_cnt + 8'd1;
            end else if (drop_valid) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Backdoor byte-masked write; a same-cycle read of this word sees the old value.
    always_ff @(posedge clk) begin
        if (bd_wen && bd_in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (bd_wstrb[b]) begin
                    mem[bd_idx][8*b +: 8] <= bd_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/axi_rd_mem_slave.md
Name: axi_rd_mem_slave

Overview:
AXI4 read-only memory slave sitting directly downstream of the core's AR/R master port; it serves both instruction fetches and data loads. It accepts one read address at a time, waits a programmable latency, then returns ARLEN+1 data beats from an internal word array. A simple backdoor write port lets the bench or stores preload and update memory contents.

Parameters:
ID_W, 4, width of ARID/RID
DATA_W, 64, data bus width in bits; fixed at 64, 8-byte words
MEM_WORDS, 4096, number of 64-bit words; power of two
MEM_BASE, 64'h8000_0000, byte address of word 0
RD_LATENCY, 2, cycles from AR handshake to first RVALID; must be at least 1
STALL_SEED, 16'hACE1, LFSR seed used only with AXI_RD_STALL_EN

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset, synchronous, active-high
ARID  in  ID_W  transaction ID
ARADDR  in  64  byte address
ARLEN  in  8  beats minus 1
ARSIZE  in  3  log2 bytes per beat
ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
ARVALID  in  1  address valid
ARREADY  out  1  address accept
RID  out  ID_W  echoes the captured ARID
RDATA  out  64  read data
RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
RLAST  out  1  final beat
RVALID  out  1  data valid
RREADY  in  1  master accepts data
bd_wen  in  1  backdoor write enable
bd_waddr  in  64  backdoor byte address
bd_wdata  in  64  backdoor write data
bd_wstrb  in  8  backdoor byte strobes

Behaviour:
- Reset (rst=1 at posedge) drives state to IDLE, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0. Memory contents are not cleared. Reset mid-burst abandons the burst with no further beats.
- The FSM has three states: IDLE, WAIT and BURST.
- IDLE: ARREADY=1 in the cycle after reset deasserts. On ARVALID&ARREADY, capture ID, address, length, size and burst type, load the latency counter with RD_LATENCY-1, go to WAIT, and drop ARREADY.
- WAIT: decrement the counter each cycle. When it reaches 0, read the first beat into the R registers, assert RVALID, and go to BURST. First RVALID therefore appears RD_LATENCY cycles after the AR handshake.
- BURST: RDATA, RRESP, RLAST and RID hold stable while RVALID&!RREADY. On RVALID&RREADY:
  - Last beat: RVALID drops next cycle and the FSM returns to IDLE, so ARREADY=1 the cycle after the last handshake. There are no back-to-back bursts and at most one transaction is outstanding.
  - Otherwise: load the next beat in the following cycle, giving zero-bubble streaming.
- Beat counter counts 0..ARLEN. RLAST is set when beat == ARLEN. ARLEN=0 gives a single beat with RLAST=1.
- Address advance, with step = 1<<ARSIZE:
  - FIXED: address unchanged.
  - INCR: address += step, 64-bit wrap.
  - WRAP: container = step*(ARLEN+1), aligned down; the address wraps to the container base on crossing its top.
- Data selection: word index = (addr-MEM_BASE)>>3. RDATA is the full 64-bit word for every size; the master selects lanes.
- Errors, evaluated per beat; an error beat still counts, asserts RVALID and carries RDATA=0:
  - Address outside [MEM_BASE, MEM_BASE+8*MEM_WORDS): DECERR.
  - ARSIZE>3: SLVERR on all beats.
  - WRAP with ARLEN not in {1,3,7,15}: SLVERR on all beats.
- Backdoor: when bd_wen, bytes with bd_wstrb set are written at the clock edge. Out-of-range backdoor writes are ignored. A write and a read of the same word in the same cycle: the read returns the old data.

Optional Feature:
- Macro: AXI_RD_STALL_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with STALL_SEED at reset, advances every cycle. In BURST, when the LFSR bit0=1 before a beat is presented, RVALID is held low for one cycle. A stall never occurs once RVALID is high, and never in the cycle after the last handshake.
- Undefined: no LFSR, with streaming as described above.

Decomposition:
- Package axi_pkg holds:
  - burst constants BURST_FIXED/INCR/WRAP;
  - response constants RESP_OKAY/SLVERR/DECERR;
  - the rd_state_t enum {IDLE, WAIT, BURST}.
- Sub-module axi_burst_addr_gen: combinational next-address calculation from (addr, size, len, burst) producing the next address. It is shared with a future write slave.

Test Plan:
- Preload word0=64'h1111, word1=64'h2222 via backdoor; AR INCR addr 0x8000_0000 len 1 size 3, RREADY=1 -> RVALID 2 cycles after handshake, beats 1111 then 2222 on consecutive cycles, RLAST on beat 2, RRESP=00.
- WRAP len 3 size 3 addr 0x8000_0010 -> word indices 2,3,0,1, RLAST on the fourth beat.
- RREADY toggled 0,0,1 on each beat -> RDATA/RLAST/RID stable while stalled; ARREADY stays 0 until the cycle after the last handshake.
- Addr 0x7FFF_FFF8 INCR len 1 -> beat1 DECERR RDATA=0, beat2 (0x8000_0000) OKAY word0.
- ARSIZE=4 len 2 -> 3 beats, all SLVERR; WRAP len 2 -> SLVERR on all beats.
- rst asserted while RVALID=1 mid-burst -> next cycle RVALID=0, ARREADY=0, then ARREADY=1 after release; a new AR completes normally.
